// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Provides XLEN, the NOP encoding, fetch FSM states and queue entry layout.
package if_prefetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries for the prefetch path.
// Ports: push/wr_data, pop, clear (wins over both), head, count, empty, full.
module fetch_queue
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  fq_entry_t   wr_data,
    output fq_entry_t   head,
    output logic [AW:0] count,
    output logic        empty,
    output logic        full
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/if_prefetch.sv
// Fetch front end: variable-latency imem handshake feeding a prefetch queue.
// Ports: clk/reset, IFWrite pop, Branch/Jump/JumpAddr redirect, imem_* bus,
// Instruction_if/PC/IF_valid head view, IF_flush = Branch|Jump.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IFWrite,
    input  logic            Branch,
    input  logic            Jump,
    input  logic [XLEN-1:0] JumpAddr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instruction_if,
    output logic [XLEN-1:0] PC,
    output logic            IF_valid,
    output logic            IF_flush
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_state_e    state;
    fetch_state_e    state_d;
    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] fpc_d;
    logic            req_d;
    logic [XLEN-1:0] addr_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            push;
    logic            pop;
    logic [AW:0]     count;
    logic [AW:0]     cnt_after;
    logic            q_empty;
    logic            q_full;
    fq_entry_t       head;
    fq_entry_t       wr_data;
    logic            jaddr_unused;

    assign redirect     = Branch | Jump;
    assign IF_flush     = redirect;
    assign target       = {JumpAddr[XLEN-1:2], 2'b00};
    assign jaddr_unused = ^JumpAddr[1:0];

    assign push = (state == BUSY) & imem_ack & ~redirect;
    assign pop  = IFWrite & ~q_empty;

    // Occupancy after this cycle's push/pop decides whether to keep streaming.
    assign cnt_after = count + (AW+1)'(push) - (AW+1)'(pop);

    assign wr_data.pc    = imem_addr;
    assign wr_data.instr = imem_rdata;

    assign IF_valid       = ~q_empty;
    assign Instruction_if = q_empty ? NOP : head.instr;
    assign PC             = q_empty ? fpc : head.pc;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .clear   (redirect),
        .wr_data (wr_data),
        .head    (head),
        .count   (count),
        .empty   (q_empty),
        .full    (q_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_d;
            fpc       <= fpc_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
        end
    end

    always_comb begin
        state_d = state;
        fpc_d   = fpc;
        req_d   = imem_req;
        addr_d  = imem_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fpc_d = target;
                end else if (count < FULL_CNT) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    addr_d  = fpc;
                end
            end
            BUSY: begin
                if (redirect) begin
                    fpc_d = target;
                    // An in-flight request must still complete; its
                    // response is swallowed in DROP.
                    if (imem_ack) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    fpc_d = fpc + 32'd4;
                    if (cnt_after < FULL_CNT) begin
                        addr_d = fpc + 32'd4;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DROP: begin
                if (redirect) fpc_d = target;
                if (imem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: per-cycle vector table plus corner sequences.
// Memory model acks after a programmable number of wait cycles.
module tb_if_prefetch;

    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] KEY     = 32'hC0DE_0000;
    localparam logic [31:0] NOP_EXP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IFWrite = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] JumpAddr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction_if;
    logic [31:0] PC;
    logic        IF_valid;
    logic        IF_flush;

    int          lat = 0;
    logic [3:0]  wcnt;
    int          total = 0;
    int          passed = 0;
    int          viol = 0;

    if_prefetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .IFWrite        (IFWrite),
        .Branch         (Branch),
        .Jump           (Jump),
        .JumpAddr       (JumpAddr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .Instruction_if (Instruction_if),
        .PC             (PC),
        .IF_valid       (IF_valid),
        .IF_flush       (IF_flush)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset)                  wcnt <= '0;
        else if (!imem_req || imem_ack) wcnt <= '0;
        else                        wcnt <= wcnt + 4'd1;
    end

    assign imem_ack   = imem_req && (int'(wcnt) == lat);
    assign imem_rdata = imem_addr ^ KEY;

    always @(negedge clk) begin
        if (!reset && dut.push && dut.q_full) viol = viol + 1;
    end

    typedef struct {
        bit          rst;
        bit          ifw;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_out(input string tag, input bit req,
                           input logic [31:0] addr, input bit valid,
                           input logic [31:0] pc);
        chk({tag, ".req"}, imem_req, req);
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".valid"}, IF_valid, valid);
        chk({tag, ".pc"}, PC, pc);
        chk({tag, ".instr"}, Instruction_if, valid ? (pc ^ KEY) : NOP_EXP);
    endtask

    initial begin
        int n;
        vt[0]  = '{1, 1, 0, 32'h100, 0, 32'h100};
        vt[1]  = '{0, 1, 1, 32'h100, 0, 32'h100};
        vt[2]  = '{0, 1, 1, 32'h104, 1, 32'h100};
        vt[3]  = '{0, 1, 1, 32'h108, 1, 32'h104};
        vt[4]  = '{0, 1, 1, 32'h10C, 1, 32'h108};
        vt[5]  = '{1, 0, 0, 32'h100, 0, 32'h100};
        vt[6]  = '{0, 0, 1, 32'h100, 0, 32'h100};
        vt[7]  = '{0, 0, 1, 32'h104, 1, 32'h100};
        vt[8]  = '{0, 0, 0, 32'h104, 1, 32'h100};
        vt[9]  = '{0, 0, 0, 32'h104, 1, 32'h100};
        vt[10] = '{0, 0, 0, 32'h104, 1, 32'h100};
        vt[11] = '{0, 1, 0, 32'h104, 1, 32'h104};
        vt[12] = '{0, 1, 1, 32'h108, 0, 32'h108};
        vt[13] = '{0, 1, 1, 32'h10C, 1, 32'h108};
        vt[14] = '{0, 1, 1, 32'h110, 1, 32'h10C};

        #2;
        chk("rst.flush", IF_flush, 0);
        lat = 0;
        for (int i = 0; i < 15; i++) begin
            if (vt[i].rst) reset = 1'b1;
            IFWrite = vt[i].ifw;
            tick();
            chk_out($sformatf("vec%0d", i), vt[i].req, vt[i].addr,
                    vt[i].valid, vt[i].pc);
            if (vt[i].rst) reset = 1'b0;
        end

        // 3-cycle memory: address held, one word every third cycle
        lat = 2;
        IFWrite = 1'b1;
        rst_pulse();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("lat%0d.a", i), 1, RST_PC + 32'(4 * i),
                    i > 0, i > 0 ? RST_PC + 32'(4 * (i - 1)) : RST_PC + 32'(4 * i));
            tick();
            chk($sformatf("lat%0d.b.req", i), imem_req, 1);
            chk($sformatf("lat%0d.b.addr", i), imem_addr, RST_PC + 32'(4 * i));
            chk($sformatf("lat%0d.b.valid", i), IF_valid, 0);
            tick();
            chk($sformatf("lat%0d.c.addr", i), imem_addr, RST_PC + 32'(4 * i));
            chk($sformatf("lat%0d.c.valid", i), IF_valid, 0);
        end

        // jump while waiting for ack: stale word dropped
        lat = 2;
        IFWrite = 1'b1;
        rst_pulse();
        tick();
        chk("jmp.issue", imem_addr, 32'h100);
        Jump = 1'b1;
        JumpAddr = 32'h200;
        #1;
        chk("jmp.flush1", IF_flush, 1);
        tick();
        Jump = 1'b0;
        #1;
        chk("jmp.flush0", IF_flush, 0);
        chk_out("jmp.drop", 1, 32'h100, 0, 32'h200);
        tick();
        chk("jmp.wait.valid", IF_valid, 0);
        tick();
        chk_out("jmp.stale", 0, 32'h100, 0, 32'h200);
        tick();
        chk_out("jmp.reissue", 1, 32'h200, 0, 32'h200);
        n = 0;
        while (!IF_valid && n < 10) begin
            tick();
            n++;
        end
        chk("jmp.lat", n, 3);
        chk("jmp.pc", PC, 32'h200);
        chk("jmp.instr", Instruction_if, 32'h200 ^ KEY);

        // branch coinciding with ack: response dropped
        lat = 1;
        IFWrite = 1'b1;
        rst_pulse();
        tick();
        tick();
        chk("br.ack", imem_ack, 1);
        Branch = 1'b1;
        JumpAddr = 32'h403;
        #1;
        chk("br.flush1", IF_flush, 1);
        tick();
        Branch = 1'b0;
        #1;
        chk("br.flush0", IF_flush, 0);
        chk_out("br.idle", 0, 32'h100, 0, 32'h400);
        tick();
        chk_out("br.issue", 1, 32'h400, 0, 32'h400);
        tick();
        tick();
        chk_out("br.head", 1, 32'h404, 1, 32'h400);

        // async reset in the middle of a request
        lat = 2;
        IFWrite = 1'b1;
        rst_pulse();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk_out("mrst", 0, RST_PC, 0, RST_PC);
        tick();
        reset = 1'b0;
        tick();
        chk_out("mrst.issue", 1, RST_PC, 0, RST_PC);
        n = 0;
        while (!IF_valid && n < 10) begin
            tick();
            n++;
        end
        chk("mrst.lat", n, 3);
        chk("mrst.pc", PC, RST_PC);

        // fetch PC wraps past the top of the address space
        lat = 0;
        IFWrite = 1'b1;
        rst_pulse();
        Jump = 1'b1;
        JumpAddr = 32'hFFFF_FFFF;
        tick();
        Jump = 1'b0;
        #1;
        chk_out("wrap.idle", 0, RST_PC, 0, 32'hFFFF_FFFC);
        tick();
        chk_out("wrap.issue", 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
        tick();
        chk_out("wrap.top", 1, 32'h0, 1, 32'hFFFF_FFFC);
        tick();
        chk_out("wrap.zero", 1, 32'h4, 1, 32'h0);

        chk("no_full_push", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
